even_issue_scoreboard: RTL and testbench
========================================

// Module: even_issue_scoreboard
// PURPOSE
//  Issue controller for the 7-stage even pipe. Sits between decode and the
//  even pipe. Tracks in-flight destination registers with a per-stage
//  scoreboard and stalls decode on RAW hazards. Selects the forwarding source
//  (register file or packed_1stage..packed_7stage) for each source operand.
//  Keeps issue and stall performance counters.
// PARAMETERS
//  NSTAGE   7    pipe depth; entries tracked for stages 1..NSTAGE
//  CNT_W    32   width of the issue/stall performance counters
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      asynchronous, active-low reset
//  dec_valid       in   1      decode presents an instruction
//  dec_ready       out  1      scoreboard accepts the instruction this cycle
//  dec_reg_dst     in   [0:6]  destination register
//  dec_reg_wr      in   1      instruction writes dec_reg_dst
//  dec_latency     in   [0:3]  stage at which the result becomes valid
//  dec_ra/rb/rc    in   [0:6]  source register addresses
//  dec_use_ra/rb/rc in  1      source is actually read
//  flush           in   1      kill all in-flight tracking
//  issue_valid     out  1      instruction enters even-pipe stage 1 next edge
//  fwd_ra/rb/rc_sel out [0:2]  0 = register file, k = packed_kstage
//  issue_cnt       out  CNT_W  instructions issued since reset
//  stall_cnt       out  CNT_W  cycles with dec_valid=1 and dec_ready=0
// BEHAVIOUR
//  - Scoreboard: NSTAGE entries {v, dst, wr, lat}, one per stage. Each edge
//    entry k moves to k+1. Entry NSTAGE is dropped because WB retires it.
//    Entry 1 loads {issue_valid, dec_reg_dst, dec_reg_wr, clamp(dec_latency)}.
//  - clamp: latency 0 or 1 -> 1; latency > NSTAGE -> NSTAGE.
//  - Match for source X at stage k: v & wr & use_X & (dst == X).
//  - Hazard: any match at stage k with k < lat. The result is not yet
//    produced, so dec_ready = 0.
//  - Match with k >= lat gives no hazard. fwd_X_sel = smallest such k, so the
//    youngest producer wins. No match gives fwd_X_sel = 0.
//  - A stage-NSTAGE match still forwards from stage 7, because the RF write
//    occurs that same cycle.
//  - Register r0 is an ordinary register and is not exempt from hazards.
//  - dec_ready = ~hazard & ~flush. issue_valid = dec_valid & dec_ready.
//    Both are combinational.
//  - fwd selects are combinational and valid whenever issue_valid = 1.
//  - On a stall, a bubble (v=0) enters stage 1. Decode holds its inputs
//    stable until dec_ready = 1.
//  - flush: all entries go to v=0 at the next edge. No issue occurs in the
//    flush cycle. Flush has priority over a simultaneous issue.
//  - issue_cnt increments on issue_valid. stall_cnt increments on
//    dec_valid & ~dec_ready & ~flush. Both wrap at 2^CNT_W.
//  - Reset (rst=0, async): all entries v=0, counters 0, dec_ready=1,
//    issue_valid follows dec_valid, fwd selects 0.
//    Mid-operation reset discards all in-flight tracking immediately.
// TESTING
//  - Reset: rst=0 mid-stream -> immediately issue_cnt=0, stall_cnt=0, all
//    fwd_sel=0. After release, dec_valid=1 with independent srcs -> dec_ready=1.
//  - Back-to-back dependency: I1 dst=7 lat=2, then I2 ra=7 -> 1 stall cycle,
//    I2 issues with fwd_ra_sel=2, stall_cnt=1.
//  - Long latency: I1 dst=20 lat=7, next I2 rb=20 -> 6 stall cycles, issues
//    with fwd_rb_sel=7, stall_cnt=6.
//  - Independent stream: 10 instructions with disjoint regs -> no stalls,
//    issue_cnt=10, all fwd_sel=0.
//  - Youngest wins: producers of r5 lat=2 at stages 3 and 5, consumer rc=5 ->
//    fwd_rc_sel=3. With dec_use_rc=0 -> fwd_rc_sel=0 and no stall.
//  - Flush while stalled on r9: flush=1 for one cycle -> dec_ready=0 that
//    cycle. Next cycle dec_ready=1, fwd_sel=0, stall_cnt unchanged by the
//    flush cycle.

Source files
------------

// File: rtl/even_issue_scoreboard_if.sv
// Decode-to-even-pipe issue interface: instruction bundle in,
// accept/issue strobes and forwarding selects out.
interface even_issue_scoreboard_if;
    logic       dec_valid;
    logic       dec_ready;
    logic [0:6] dec_reg_dst;
    logic       dec_reg_wr;
    logic [0:3] dec_latency;
    logic [0:6] dec_ra;
    logic [0:6] dec_rb;
    logic [0:6] dec_rc;
    logic       dec_use_ra;
    logic       dec_use_rb;
    logic       dec_use_rc;
    logic       issue_valid;
    logic [0:2] fwd_ra_sel;
    logic [0:2] fwd_rb_sel;
    logic [0:2] fwd_rc_sel;

    modport master (
        output dec_valid, dec_reg_dst, dec_reg_wr, dec_latency,
        output dec_ra, dec_rb, dec_rc,
        output dec_use_ra, dec_use_rb, dec_use_rc,
        input  dec_ready, issue_valid,
        input  fwd_ra_sel, fwd_rb_sel, fwd_rc_sel
    );

    modport slave (
        input  dec_valid, dec_reg_dst, dec_reg_wr, dec_latency,
        input  dec_ra, dec_rb, dec_rc,
        input  dec_use_ra, dec_use_rb, dec_use_rc,
        output dec_ready, issue_valid,
        output fwd_ra_sel, fwd_rb_sel, fwd_rc_sel
    );
endinterface

// File: rtl/even_issue_scoreboard.sv
// Even-pipe issue scoreboard: per-stage destination tracking,
// RAW stall generation, forwarding select and perf counters.
module even_issue_scoreboard #(
    parameter int NSTAGE = 7,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    even_issue_scoreboard_if.slave dec,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef struct packed {
        logic       v;
        logic [0:6] dst;
        logic       wr;
        logic [0:3] lat;
    } entry_t;

    entry_t           r_sb [1:NSTAGE];
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_hazard;
    logic       w_ready;
    logic       w_issue;
    logic       w_stall;
    logic [0:3] w_lat_clamp;
    logic [0:6] w_src [3];
    logic       w_use [3];
    logic [0:2] w_sel [3];

    always_comb begin
        w_src[0] = dec.dec_ra;
        w_src[1] = dec.dec_rb;
        w_src[2] = dec.dec_rc;
        w_use[0] = dec.dec_use_ra;
        w_use[1] = dec.dec_use_rb;
        w_use[2] = dec.dec_use_rc;
    end

    always_comb begin
        if (dec.dec_latency <= 4'd1)
            w_lat_clamp = 4'd1;
        else if (int'(dec.dec_latency) > NSTAGE)
            w_lat_clamp = 4'(NSTAGE);
        else
            w_lat_clamp = dec.dec_latency;
    end

    // Oldest-to-youngest scan so the youngest ready producer wins.
    always_comb begin
        w_hazard = 1'b0;
        for (int s = 0; s < 3; s++) begin
            w_sel[s] = '0;
            for (int k = NSTAGE; k >= 1; k--) begin
                if (r_sb[k].v && r_sb[k].wr && w_use[s] &&
                    (r_sb[k].dst == w_src[s])) begin
                    if (k < int'(r_sb[k].lat))
                        w_hazard = 1'b1;
                    else
                        w_sel[s] = 3'(k);
                end
            end
        end
    end

    assign w_ready = ~w_hazard & ~flush;
    assign w_issue = dec.dec_valid & w_ready;
    assign w_stall = dec.dec_valid & ~w_ready & ~flush;

    assign dec.dec_ready   = w_ready;
    assign dec.issue_valid = w_issue;
    assign dec.fwd_ra_sel  = w_sel[0];
    assign dec.fwd_rb_sel  = w_sel[1];
    assign dec.fwd_rc_sel  = w_sel[2];

    assign issue_cnt = r_issue_cnt;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= NSTAGE; k++)
                r_sb[k] <= '0;
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                for (int k = 1; k <= NSTAGE; k++)
                    r_sb[k] <= '0;
            end else begin
                r_sb[1] <= '{v:   w_issue,
                             dst: dec.dec_reg_dst,
                             wr:  dec.dec_reg_wr,
                             lat: w_lat_clamp};
                for (int k = 2; k <= NSTAGE; k++)
                    r_sb[k] <= r_sb[k-1];
            end
            if (w_issue)
                r_issue_cnt <= r_issue_cnt + 1'b1;
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_even_issue_scoreboard.sv
// Bench for even_issue_scoreboard: vector table, directed corner
// sequences and random traffic against a timestamp-based model.
module tb_even_issue_scoreboard;

    localparam int NSTAGE = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    even_issue_scoreboard_if dif ();

    even_issue_scoreboard #(.NSTAGE(NSTAGE), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .dec       (dif),
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
    );

    // In-flight instruction: issued at cycle t, sits in stage (cyc - t).
    typedef struct {
        int       t;
        bit [6:0] dst;
        bit       wr;
        int       lat;
    } rec_t;

    typedef struct {
        bit       fl;
        bit       v;
        bit [6:0] dst;
        bit       wr;
        bit [3:0] lat;
        bit [6:0] ra, rb, rc;
        bit       ua, ub, uc;
        bit       e_rdy;
        int       e_ra, e_rb, e_rc;
    } vec_t;

    rec_t        q[$];
    vec_t        tbl[$];
    int          cyc;
    logic [31:0] m_issue, m_stall;
    int          n_chk, n_fail;
    bit          e_ready, e_iv;
    int          e_sel[3];
    bit          s_ready, s_iv;
    int          s_sel[3];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    function automatic int clamp(input int lat);
        if (lat <= 1) return 1;
        if (lat > NSTAGE) return NSTAGE;
        return lat;
    endfunction

    function automatic void model_eval();
        bit       hz;
        int       best, s;
        bit [6:0] src[3];
        bit       u[3];
        src[0] = dif.dec_ra; src[1] = dif.dec_rb; src[2] = dif.dec_rc;
        u[0] = dif.dec_use_ra; u[1] = dif.dec_use_rb; u[2] = dif.dec_use_rc;
        hz = 0;
        for (int i = 0; i < 3; i++) begin
            best = 0;
            foreach (q[j]) begin
                s = cyc - q[j].t;
                if (s >= 1 && s <= NSTAGE && q[j].wr && u[i] &&
                    q[j].dst == src[i]) begin
                    if (s < q[j].lat) hz = 1;
                    else if (best == 0 || s < best) best = s;
                end
            end
            e_sel[i] = best;
        end
        e_ready = !hz && !flush;
        e_iv    = dif.dec_valid && e_ready;
    endfunction

    // Called at posedge+1; checks mid-cycle, then advances the model.
    task automatic step();
        #4;
        model_eval();
        s_ready  = dif.dec_ready;
        s_iv     = dif.issue_valid;
        s_sel[0] = dif.fwd_ra_sel;
        s_sel[1] = dif.fwd_rb_sel;
        s_sel[2] = dif.fwd_rc_sel;
        chk("dec_ready", dif.dec_ready, e_ready);
        chk("issue_valid", dif.issue_valid, e_iv);
        chk("fwd_ra_sel", dif.fwd_ra_sel, e_sel[0]);
        chk("fwd_rb_sel", dif.fwd_rb_sel, e_sel[1]);
        chk("fwd_rc_sel", dif.fwd_rc_sel, e_sel[2]);
        chk("issue_cnt", issue_cnt, m_issue);
        chk("stall_cnt", stall_cnt, m_stall);
        @(posedge clk);
        if (flush) q.delete();
        else if (e_iv)
            q.push_back('{cyc, dif.dec_reg_dst, dif.dec_reg_wr,
                          clamp(int'(dif.dec_latency))});
        if (e_iv) m_issue++;
        if (dif.dec_valid && !e_ready && !flush) m_stall++;
        cyc++;
        while (q.size() > 0 && cyc - q[0].t > NSTAGE) void'(q.pop_front());
        #1;
    endtask

    task automatic drive(input bit v, input int dst, input bit wr,
                         input int lat, input int ra, input int rb,
                         input int rc, input bit ua, input bit ub,
                         input bit uc);
        dif.dec_valid   = v;
        dif.dec_reg_dst = 7'(dst);
        dif.dec_reg_wr  = wr;
        dif.dec_latency = 4'(lat);
        dif.dec_ra      = 7'(ra);
        dif.dec_rb      = 7'(rb);
        dif.dec_rc      = 7'(rc);
        dif.dec_use_ra  = ua;
        dif.dec_use_rb  = ub;
        dif.dec_use_rc  = uc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clean();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    function automatic vec_t mk(bit fl, bit v, int dst, bit wr, int lat,
                                int ra, int rb, int rc, bit ua, bit ub,
                                bit uc, bit rdy, int sa, int sb, int sc);
        vec_t r;
        r.fl = fl; r.v = v; r.dst = 7'(dst); r.wr = wr; r.lat = 4'(lat);
        r.ra = 7'(ra); r.rb = 7'(rb); r.rc = 7'(rc);
        r.ua = ua; r.ub = ub; r.uc = uc;
        r.e_rdy = rdy; r.e_ra = sa; r.e_rb = sb; r.e_rc = sc;
        return r;
    endfunction

    initial begin
        int          n, base;
        bit          done, held;
        logic [31:0] b;
        n_chk = 0; n_fail = 0; cyc = 0; m_issue = 0; m_stall = 0;
        idle();

        // Reset state while rst is low.
        #2;
        chk("rst_issue_cnt", issue_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_ready", dif.dec_ready, 1);
        chk("rst_fwd_ra", dif.fwd_ra_sel, 0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // fl v dst wr lat ra rb rc ua ub uc | rdy sa sb sc
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 1, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8, 1, 1, 7, 0, 0, 1, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 30, 1, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 30, 1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 3, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 12, 1, 1, 0, 11, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 13, 0, 1, 0, 12, 0, 0, 1, 0, 1, 0, 1, 0));

        foreach (tbl[i]) begin
            flush = tbl[i].fl;
            drive(tbl[i].v, tbl[i].dst, tbl[i].wr, tbl[i].lat, tbl[i].ra,
                  tbl[i].rb, tbl[i].rc, tbl[i].ua, tbl[i].ub, tbl[i].uc);
            step();
            chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_ra", i), s_sel[0], tbl[i].e_ra);
            chk($sformatf("tbl%0d_rb", i), s_sel[1], tbl[i].e_rb);
            chk($sformatf("tbl%0d_rc", i), s_sel[2], tbl[i].e_rc);
        end
        flush = 1'b0;

        // Long latency producer: six stall cycles, forward from stage 7.
        clean();
        b = m_stall;
        drive(1, 20, 1, 7, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 21, 1, 1, 1, 20, 2, 0, 1, 0);
        n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (s_ready) done = 1;
            else n++;
        end
        chk("long_issued", done, 1);
        chk("long_stalls", n, 6);
        chk("long_fwd_rb", s_sel[1], 7);
        chk("long_stall_cnt", stall_cnt, b + 32'd6);

        // Independent stream: no stalls, ten issues.
        b = m_issue;
        for (int i = 0; i < 10; i++) begin
            drive(1, 40 + i, 1, $urandom_range(0, 9), 60 + i, 80 + i,
                  100 + i, 1, 1, 1);
            step();
            chk("indep_ready", s_ready, 1);
            chk("indep_fwd", s_sel[0] + s_sel[1] + s_sel[2], 0);
        end
        chk("indep_issue_cnt", issue_cnt, b + 32'd10);

        // Flush while stalled on r9.
        clean();
        drive(1, 9, 1, 4, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 10, 1, 1, 9, 0, 0, 1, 0, 0);
        step();
        chk("fl_stalled", s_ready, 0);
        b = m_stall;
        flush = 1'b1;
        step();
        chk("fl_ready_in_flush", s_ready, 0);
        chk("fl_no_issue", s_iv, 0);
        flush = 1'b0;
        chk("fl_stall_cnt", stall_cnt, b);
        step();
        chk("fl_ready_after", s_ready, 1);
        chk("fl_fwd_ra", s_sel[0], 0);

        // Random traffic over a small register set to provoke hazards.
        held = 0;
        for (int i = 0; i < 3000; i++) begin
            flush = ($urandom_range(0, 99) < 3);
            if (!held)
                drive($urandom_range(0, 99) < 80, $urandom_range(0, 7),
                      1'($urandom), $urandom_range(0, 9),
                      $urandom_range(0, 7), $urandom_range(0, 7),
                      $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                      1'($urandom));
            step();
            held = dif.dec_valid && !s_ready && !flush;
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream with a pending hazard.
        clean();
        drive(1, 3, 1, 5, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 4, 1, 1, 3, 0, 0, 1, 0, 0);
        step();
        chk("pre_rst_stall", s_ready, 0);
        #4;
        rst = 1'b0;
        #1;
        chk("mid_rst_issue_cnt", issue_cnt, 0);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
        chk("mid_rst_ready", dif.dec_ready, 1);
        chk("mid_rst_issue_valid", dif.issue_valid, 1);
        chk("mid_rst_fwd_ra", dif.fwd_ra_sel, 0);
        q.delete();
        m_issue = 0;
        m_stall = 0;
        idle();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        drive(1, 50, 1, 3, 51, 52, 53, 1, 1, 1);
        step();
        chk("post_rst_ready", s_ready, 1);
        idle();
        step();
        chk("post_rst_issue_cnt", issue_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
